rega_multizona: RTL and testbench

Multi-zone irrigation sequencer for the automatic irrigation controller. It serves NZONES independent soil-humidity requests one at a time, in round-robin order. Each zone runs a fixed-duration sprinkler or drip cycle. The block refills the shared tank when the level reads empty and can optionally run a fertilizer mix followed by a line-cleaning cycle. It sits between the sensor inputs and the valve drivers; the display selector reads its status outputs.

---
 rtl/rega_pkg.sv | 22 ++
 rtl/rega_rr_arb.sv | 35 +++
 rtl/rega_multizona.sv | 204 ++++++++++++++++++++
 tb/tb_rega_multizona.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// Shared types and constants for the multi-zone irrigation sequencer.
// Imported by rega_rr_arb and rega_multizona.
package rega_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    CLEAN = 2'd3
  } rega_state_e;

  localparam logic [1:0] NV_EMPTY = 2'b00;
  localparam logic [1:0] NV_FULL  = 2'b11;

  localparam logic MODE_ASP = 1'b1;
  localparam logic MODE_GOT = 1'b0;

  function automatic logic tank_empty(input logic [1:0] nv);
    return (nv == NV_EMPTY);
  endfunction

endpackage

// File: rtl/rega_rr_arb.sv
// Combinational round-robin arbiter: picks the first requesting zone at or
// after ptr, searching upward and wrapping. The pointer register is the parent's.
module rega_rr_arb
  import rega_pkg::*;
#(
  parameter int NZONES = 4
) (
  input  logic [NZONES-1:0]         req,
  input  logic [$clog2(NZONES)-1:0] ptr,
  output logic                      grant_valid,
  output logic [$clog2(NZONES)-1:0] grant_idx
);

  localparam int ZW = $clog2(NZONES);

  logic [ZW-1:0] idx_s;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx_s       = '0;
    for (int k = NZONES - 1; k >= 0; k--) begin
      idx_s = ZW'((int'(ptr) + k) % NZONES);
      if (req[idx_s]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_s;
      end else begin
        grant_valid = grant_valid;
        grant_idx   = grant_idx;
      end
    end
  end

endmodule

// File: rtl/rega_multizona.sv
// Multi-zone irrigation sequencer: round-robin zone service, tank refill, and
// optional fertilizer mix + line cleaning enabled by macro REGA_ADUB_EN.
module rega_multizona
  import rega_pkg::*;
#(
  parameter int NZONES      = 4,
  parameter int TIMER_W     = 8,
  parameter int ASP_TICKS   = 20,
  parameter int GOT_TICKS   = 40,
  parameter int CLEAN_TICKS = 10
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Tick,
  input  logic [NZONES-1:0]         Us,
  input  logic [NZONES-1:0]         Vs,
  input  logic [1:0]                Nv,
  input  logic                      Adub,
  output logic [NZONES-1:0]         A,
  output logic [NZONES-1:0]         G,
  output logic                      Ve,
  output logic                      Mist,
  output logic                      Limp,
  output logic [$clog2(NZONES)-1:0] Zone,
  output logic [TIMER_W-1:0]        Remaining,
  output logic                      Busy
);

  localparam int ZW = $clog2(NZONES);

`ifdef REGA_ADUB_EN
  localparam logic ADUB_EN = 1'b1;
`else
  localparam logic ADUB_EN = 1'b0;
`endif

  localparam logic [TIMER_W-1:0] CNT_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] ASP_LOAD   = TIMER_W'(ASP_TICKS);
  localparam logic [TIMER_W-1:0] GOT_LOAD   = TIMER_W'(GOT_TICKS);
  localparam logic [TIMER_W-1:0] CLEAN_LOAD = TIMER_W'(CLEAN_TICKS);
  localparam logic [ZW-1:0]      ZONE_LAST  = ZW'(NZONES - 1);
  localparam logic [ZW-1:0]      ZONE_ONE   = ZW'(1);
  localparam logic [NZONES-1:0]  VALVE_BIT0 = {{(NZONES-1){1'b0}}, 1'b1};

  rega_state_e        state_q, state_d;
  logic [ZW-1:0]      ptr_q, ptr_d;
  logic [ZW-1:0]      zone_q, zone_d;
  logic               mode_q, mode_d;
  logic               fert_q, fert_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [NZONES-1:0]  a_q, a_d;
  logic [NZONES-1:0]  g_q, g_d;
  logic               ve_q, ve_d;
  logic               mist_q, mist_d;
  logic               limp_q, limp_d;
  logic               busy_q, busy_d;

  logic               grant_valid_s;
  logic [ZW-1:0]      grant_idx_s;
  logic [ZW-1:0]      next_ptr_s;

  rega_rr_arb #(
    .NZONES(NZONES)
  ) u_arb (
    .req        (Us),
    .ptr        (ptr_q),
    .grant_valid(grant_valid_s),
    .grant_idx  (grant_idx_s)
  );

  assign next_ptr_s = (zone_q == ZONE_LAST) ? '0 : (zone_q + ZONE_ONE);

  // Sequencer next state: an empty tank preempts both a new grant and a running zone.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    zone_d  = zone_q;
    mode_d  = mode_q;
    fert_d  = fert_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (tank_empty(Nv)) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (grant_valid_s) begin
          state_d = RUN;
          zone_d  = grant_idx_s;
          mode_d  = Vs[grant_idx_s];
          fert_d  = ADUB_EN & Adub;
          cnt_d   = (Vs[grant_idx_s] == MODE_ASP) ? ASP_LOAD : GOT_LOAD;
        end else begin
          cnt_d   = '0;
        end
      end
      FILL: begin
        cnt_d = '0;
        if (Nv == NV_FULL) begin
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      RUN: begin
        if (tank_empty(Nv)) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (Tick) begin
          if (cnt_q == CNT_ONE) begin
            ptr_d = next_ptr_s;
            if (fert_q) begin
              state_d = CLEAN;
              cnt_d   = CLEAN_LOAD;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      CLEAN: begin
        if (Tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Valve outputs are decoded from the next state so they move on the same edge.
  always_comb begin
    a_d = '0;
    g_d = '0;
    if (state_d == RUN) begin
      if (mode_d == MODE_ASP) begin
        a_d = VALVE_BIT0 << zone_d;
      end else begin
        g_d = VALVE_BIT0 << zone_d;
      end
    end else begin
      a_d = '0;
      g_d = '0;
    end
    ve_d   = (state_d == FILL);
    mist_d = (state_d == RUN) && fert_d;
    limp_d = (state_d == CLEAN);
    busy_d = (state_d != IDLE);
  end

  // State, arbiter pointer, grant latches and registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      zone_q  <= '0;
      mode_q  <= 1'b0;
      fert_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      g_q     <= '0;
      ve_q    <= 1'b0;
      mist_q  <= 1'b0;
      limp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      zone_q  <= zone_d;
      mode_q  <= mode_d;
      fert_q  <= fert_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      g_q     <= g_d;
      ve_q    <= ve_d;
      mist_q  <= mist_d;
      limp_q  <= limp_d;
      busy_q  <= busy_d;
    end
  end

  assign A         = a_q;
  assign G         = g_q;
  assign Ve        = ve_q;
  assign Mist      = mist_q;
  assign Limp      = limp_q;
  assign Zone      = zone_q;
  assign Remaining = cnt_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_rega_multizona.sv
// Self-checking bench for rega_multizona: directed scenarios plus randomized
// stimulus, all compared against a phase-level reference model.
`timescale 1ns/1ps
module tb_rega_multizona;

  localparam int N   = 4;
  localparam int TW  = 8;
  localparam int ASP = 5;
  localparam int GOT = 3;
  localparam int CLN = 2;

`ifdef REGA_ADUB_EN
  localparam bit ADUB_ON = 1'b1;
`else
  localparam bit ADUB_ON = 1'b0;
`endif

  logic          Clk  = 1'b0;
  logic          Rst  = 1'b0;
  logic          Tick = 1'b0;
  logic          Adub = 1'b0;
  logic [N-1:0]  Us   = 4'b0000;
  logic [N-1:0]  Vs   = 4'b0000;
  logic [1:0]    Nv   = 2'b11;
  logic [N-1:0]  A, G;
  logic          Ve, Mist, Limp, Busy;
  logic [1:0]    Zone;
  logic [TW-1:0] Remaining;
  logic [21:0]   obs_s;

  rega_multizona #(
    .NZONES(N), .TIMER_W(TW), .ASP_TICKS(ASP), .GOT_TICKS(GOT), .CLEAN_TICKS(CLN)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Us(Us), .Vs(Vs), .Nv(Nv), .Adub(Adub),
    .A(A), .G(G), .Ve(Ve), .Mist(Mist), .Limp(Limp), .Zone(Zone),
    .Remaining(Remaining), .Busy(Busy)
  );

  assign obs_s = {A, G, Ve, Mist, Limp, Zone, Remaining, Busy};

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the controller is doing, in plain terms.
  typedef enum {P_WAIT, P_REFILL, P_WATER, P_RINSE} phase_t;
  phase_t m_ph;
  int     m_ptr, m_zone, m_left;
  bit     m_sprk, m_fert;
  int     tick_ctr;
  bit     tick_rand;

  function automatic void m_reset();
    m_ph = P_WAIT; m_ptr = 0; m_zone = 0; m_left = 0; m_sprk = 1'b0; m_fert = 1'b0;
  endfunction

  function automatic void m_step();
    case (m_ph)
      P_WAIT: begin
        if (Nv == 2'b00) begin
          m_ph = P_REFILL; m_left = 0;
        end else begin
          for (int k = 0; k < N; k++) begin
            int z;
            z = (m_ptr + k) % N;
            if (Us[z] && m_ph == P_WAIT) begin
              m_zone = z; m_sprk = Vs[z]; m_fert = ADUB_ON && Adub;
              m_left = m_sprk ? ASP : GOT; m_ph = P_WATER;
            end
          end
        end
      end
      P_REFILL: if (Nv == 2'b11) m_ph = P_WAIT;
      P_WATER: begin
        if (Nv == 2'b00) begin
          m_ph = P_REFILL; m_left = 0;
        end else if (Tick) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_ptr = (m_zone + 1) % N;
            if (m_fert) begin m_ph = P_RINSE; m_left = CLN; end
            else m_ph = P_WAIT;
          end
        end
      end
      default: begin
        if (Tick) begin
          m_left = m_left - 1;
          if (m_left == 0) m_ph = P_WAIT;
        end
      end
    endcase
  endfunction

  function automatic logic [21:0] m_expect();
    logic [N-1:0] a, g;
    a = 4'b0000; g = 4'b0000;
    if (m_ph == P_WATER) begin
      if (m_sprk) a[m_zone] = 1'b1;
      else g[m_zone] = 1'b1;
    end
    return {a, g, m_ph == P_REFILL, (m_ph == P_WATER) && m_fert, m_ph == P_RINSE,
            2'(m_zone), 8'(m_left), m_ph != P_WAIT};
  endfunction

  task automatic step();
    @(posedge Clk);
    if (Rst) m_step();
    #1;
    if (tick_rand) Tick = ($urandom_range(0, 2) == 0);
    else begin
      Tick = (tick_ctr == 3);
      tick_ctr = (tick_ctr + 1) % 4;
    end
  endtask

  task automatic apply_reset();
    Rst = 1'b0; Tick = 1'b0; tick_ctr = 0; tick_rand = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    m_reset();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; Us = 4'b1111; Vs = 4'b1111; Nv = 2'b00; Adub = 1'b1; Tick = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      checks++;
      if (obs_s !== 22'd0) begin
        errors++; $display("FAIL reset_outputs got %h want 000000", obs_s);
      end
    end
  endtask

  task automatic test_sprinkler();
    int a_ticks; bit seen, done;
    apply_reset();
    Us = 4'b0001; Vs = 4'b0001; Nv = 2'b11; Adub = 1'b0;
    a_ticks = 0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL sprk_model got %h want %h", obs_s, m_expect()); end
      checks++;
      if (G !== 4'b0000) begin errors++; $display("FAIL sprk_no_drip got %b want 0000", G); end
      if (A == 4'b0001) begin
        seen = 1'b1;
        checks++;
        if (Remaining !== 8'(ASP - a_ticks)) begin
          errors++; $display("FAIL sprk_remaining got %0d want %0d", Remaining, ASP - a_ticks);
        end
        if (Tick) a_ticks++;
      end else if (seen) begin
        done = 1'b1;
        checks++;
        if (a_ticks !== ASP) begin errors++; $display("FAIL sprk_ticks got %0d want %0d", a_ticks, ASP); end
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL sprk_idle got %b want 0", Busy); end
        Us = 4'b0011;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL sprk_timeout got no completion want completion"); end
    step();
    checks++;
    if (Zone !== 2'd1 || G !== 4'b0010) begin
      errors++; $display("FAIL sprk_next_ptr got zone %0d G %b want zone 1 G 0010", Zone, G);
    end
  endtask

  task automatic test_round_robin();
    int exp_z[5] = '{0, 1, 2, 3, 0};
    int ng, gt; bit prev_busy;
    logic [N-1:0] one;
    apply_reset();
    Us = 4'b1111; Vs = 4'b0000; Nv = 2'b11; Adub = 1'b0;
    ng = 0; gt = 0; prev_busy = 1'b0; one = 4'b0001;
    for (int c = 0; c < 400 && ng < 5; c++) begin
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL rr_model got %h want %h", obs_s, m_expect()); end
      checks++;
      if (A !== 4'b0000) begin errors++; $display("FAIL rr_no_sprinkler got %b want 0000", A); end
      if (Busy && !prev_busy) begin
        checks++;
        if (Zone !== 2'(exp_z[ng]) || G !== (one << exp_z[ng])) begin
          errors++; $display("FAIL rr_order got zone %0d G %b want zone %0d", Zone, G, exp_z[ng]);
        end
        gt = 0;
      end
      if (G != 4'b0000 && Tick) gt++;
      if (!Busy && prev_busy) begin
        checks++;
        if (gt !== GOT) begin errors++; $display("FAIL rr_ticks got %0d want %0d", gt, GOT); end
        ng++;
      end
      prev_busy = Busy;
    end
    checks++;
    if (ng < 5) begin errors++; $display("FAIL rr_timeout got %0d grants want 5", ng); end
  endtask

  task automatic test_fill();
    Rst = 1'b0; Us = 4'b0010; Vs = 4'b0000; Nv = 2'b00; Adub = 1'b0;
    Tick = 1'b0; tick_ctr = 0; tick_rand = 1'b0;
    repeat (2) @(posedge Clk);
    #1; m_reset(); Rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL fill_model got %h want %h", obs_s, m_expect()); end
      checks++;
      if (Ve !== 1'b1 || A !== 4'b0000 || G !== 4'b0000) begin
        errors++; $display("FAIL fill_hold got Ve %b A %b G %b want 1 0000 0000", Ve, A, G);
      end
    end
    Nv = 2'b11;
    step();
    checks++;
    if (Ve !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL fill_exit got Ve %b Busy %b want 0 0", Ve, Busy); end
    step();
    checks++;
    if (Zone !== 2'd1 || G !== 4'b0010) begin
      errors++; $display("FAIL fill_grant got zone %0d G %b want 1 0010", Zone, G);
    end
  endtask

  task automatic test_abort();
    bit found;
    apply_reset();
    Us = 4'b0100; Vs = 4'b0000; Nv = 2'b11; Adub = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL abort_model got %h want %h", obs_s, m_expect()); end
      if (G == 4'b0100 && Remaining == 8'd2 && Tick) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_timeout got no Remaining=2 want Remaining=2"); end
    Nv = 2'b00;
    step();
    checks++;
    if ({A, G} !== 8'h00 || Ve !== 1'b1 || Remaining !== 8'd0) begin
      errors++; $display("FAIL abort_fill got A %b G %b Ve %b Rem %0d want 0000 0000 1 0", A, G, Ve, Remaining);
    end
    Nv = 2'b11;
    step();
    step();
    checks++;
    if (Zone !== 2'd2 || G !== 4'b0100 || Remaining !== 8'(GOT)) begin
      errors++; $display("FAIL abort_regrant got zone %0d G %b Rem %0d want 2 0100 %0d", Zone, G, Remaining, GOT);
    end
  endtask

  task automatic test_fert();
    int mist_t, limp_t, a_t; bit seen, done, prev_limp;
    logic [N-1:0] prev_a;
    apply_reset();
    Us = 4'b1000; Vs = 4'b1000; Adub = 1'b1; Nv = 2'b11;
    mist_t = 0; limp_t = 0; a_t = 0; seen = 1'b0; done = 1'b0; prev_limp = 1'b0; prev_a = 4'b0000;
    for (int c = 0; c < 300 && !done; c++) begin
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL fert_model got %h want %h", obs_s, m_expect()); end
      checks++;
      if (Mist !== (ADUB_ON && (A == 4'b1000))) begin
        errors++; $display("FAIL fert_mist got %b with A %b", Mist, A);
      end
      if (Busy) begin seen = 1'b1; Adub = 1'b0; Us = 4'b0000; Vs = 4'b0000; end
      if (seen && !Busy) begin
        done = 1'b1;
        checks++;
        if (ADUB_ON ? (prev_limp !== 1'b1) : (prev_a == 4'b0000)) begin
          errors++; $display("FAIL fert_exit_path got prev Limp %b prev A %b", prev_limp, prev_a);
        end
      end
      if (Tick && A == 4'b1000) a_t++;
      if (Tick && Mist) mist_t++;
      if (Tick && Limp) limp_t++;
      prev_limp = Limp; prev_a = A;
    end
    checks++;
    if (!done || a_t !== ASP || mist_t !== (ADUB_ON ? ASP : 0) || limp_t !== (ADUB_ON ? CLN : 0)) begin
      errors++; $display("FAIL fert_durations got A %0d Mist %0d Limp %0d want %0d %0d %0d",
                         a_t, mist_t, limp_t, ASP, ADUB_ON ? ASP : 0, ADUB_ON ? CLN : 0);
    end
  endtask

  task automatic test_async_reset();
    int ph;
    apply_reset();
    Us = 4'b0010; Vs = 4'b1111; Nv = 2'b11; Adub = 1'b1;
    ph = 0;
    for (int c = 0; c < 300 && ph < 3; c++) begin
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL arst_model got %h want %h", obs_s, m_expect()); end
      if (ph == 0 && Busy) begin ph = 1; Us = 4'b0000; end
      else if (ph == 1 && !Busy) begin ph = 2; Us = 4'b0100; end
      else if (ph == 2 && A == 4'b0100) ph = 3;
    end
    checks++;
    if (ph < 3) begin errors++; $display("FAIL arst_timeout got phase %0d want 3", ph); end
    step();
    step();
    #2;
    Rst = 1'b0;
    #1;
    checks++;
    if ({A, G, Ve, Mist, Limp, Busy} !== 12'h000 || Remaining !== 8'd0 || Zone !== 2'd0) begin
      errors++; $display("FAIL arst_drop got %h want 000000", obs_s);
    end
    @(posedge Clk);
    #1;
    m_reset(); tick_ctr = 0; Tick = 1'b0;
    Rst = 1'b1; Us = 4'b1111; Vs = 4'b0000; Adub = 1'b0;
    step();
    checks++;
    if (Zone !== 2'd0 || G !== 4'b0001) begin
      errors++; $display("FAIL arst_ptr got zone %0d G %b want 0 0001", Zone, G);
    end
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    tick_rand = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      Us   = 4'($urandom_range(0, 15));
      Vs   = 4'($urandom_range(0, 15));
      Adub = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 39);
      Nv   = (r == 0) ? 2'b00 : ((r < 4) ? 2'($urandom_range(1, 2)) : 2'b11);
      step();
      checks++;
      if (obs_s !== m_expect()) begin errors++; $display("FAIL rand_model got %h want %h", obs_s, m_expect()); end
      checks++;
      if ($countones({A, G}) > 1) begin errors++; $display("FAIL rand_onehot got A %b G %b want at most one", A, G); end
    end
    tick_rand = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    m_reset();
    tick_ctr = 0;
    tick_rand = 1'b0;
    test_reset();
    test_sprinkler();
    test_round_robin();
    test_fill();
    test_abort();
    test_fert();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
